// File: rtl/fsm_sched_pkg.sv
// Shared types and helpers for the fsm_req_sched round-robin scheduler.
// Holds the FSM state enum, default parameters and the round-robin pick function.
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RSP_W   = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_REQ     = 8;

  // One-hot winner: first set bit of req searching ptr, ptr+1, ... wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [3:0]         pos;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= n) pos = pos - n;
      if ((4'(k) < n) && !found && req[pos[2:0]]) begin
        pick[pos[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fsm_rr_arbiter.sv
// Combinational round-robin pick over NUM_REQ request lines.
// The pointer register lives in the parent; this block only decodes the winner.
module fsm_rr_arbiter
  import fsm_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [2:0]         pick_idx,
  output logic               pick_any
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick_ext               = rr_pick(req_ext, ptr, 4'(NUM_REQ));
    pick                   = pick_ext[NUM_REQ-1:0];
    pick_any               = |pick;
    pick_idx               = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = 3'(i);
    end
  end

endmodule

// File: rtl/fsm_req_sched.sv
// Round-robin scheduler sharing one fsm engine between NUM_REQ requesters:
// grant, issue the captured payload, then await the response with a watchdog.
module fsm_req_sched
  import fsm_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RSP_W   = DEF_RSP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        tmo_err,
  output logic [RSP_W-1:0]          rsp_data,
  output logic                      busy,
  output logic                      fsm_in_valid,
  output logic [DATA_W-1:0]         fsm_in_data,
  input  logic                      fsm_in_ready,
  input  logic                      fsm_out_valid,
  input  logic [RSP_W-1:0]          fsm_out_data,
  output sched_state_t              dbg_state,
  output logic [2:0]                dbg_rr_ptr
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t         state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           rr_ptr, ptr_n;
  logic [2:0]           gnt_idx, idx_n;
  logic [NUM_REQ-1:0]   gnt_n, done_n, tmo_n;
  logic [RSP_W-1:0]     rsp_n;
  logic                 in_valid_n, busy_n;
  logic [DATA_W-1:0]    in_data_n;

  logic [NUM_REQ-1:0]   pick;
  logic [2:0]           pick_idx;
  logic                 pick_any;
  logic [DATA_W-1:0]    pick_data;
  logic [2:0]           next_ptr;

  fsm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign next_ptr = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

  // Engine handshake: fsm_in_valid rises with the grant and stays high with
  // fsm_in_data stable until an edge sees fsm_in_ready=1; fsm_out_valid is a
  // single-cycle strobe that only counts while waiting for the response.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ptr_n      = rr_ptr;
    idx_n      = gnt_idx;
    gnt_n      = gnt;
    done_n     = '0;
    tmo_n      = '0;
    rsp_n      = rsp_data;
    in_valid_n = fsm_in_valid;
    in_data_n  = fsm_in_data;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_n      = pick;
          idx_n      = pick_idx;
          in_data_n  = pick_data;
          in_valid_n = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (fsm_in_ready) begin
          in_valid_n = 1'b0;
          cnt_n      = '0;
          state_n    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_n = cnt + 1'b1;
        // A response on the final watchdog cycle still completes normally.
        if (fsm_out_valid) begin
          rsp_n   = fsm_out_data;
          done_n  = gnt;
          gnt_n   = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_n   = gnt;
          gnt_n   = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      gnt          <= '0;
      done         <= '0;
      tmo_err      <= '0;
      rsp_data     <= '0;
      busy         <= 1'b0;
      fsm_in_valid <= 1'b0;
      fsm_in_data  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rr_ptr       <= ptr_n;
      gnt_idx      <= idx_n;
      gnt          <= gnt_n;
      done         <= done_n;
      tmo_err      <= tmo_n;
      rsp_data     <= rsp_n;
      busy         <= busy_n;
      fsm_in_valid <= in_valid_n;
      fsm_in_data  <= in_data_n;
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_fsm_req_sched.sv
// Directed + randomized bench for fsm_req_sched against a transaction-level model
// (winner search, handshake delays, response/timeout outcome, pointer advance).
module tb_fsm_req_sched;
  import fsm_sched_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = 8;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt, done, tmo_err;
  logic [RW-1:0]   rsp_data;
  logic            busy, fsm_in_valid, fsm_in_ready, fsm_out_valid;
  logic [DW-1:0]   fsm_in_data;
  logic [RW-1:0]   fsm_out_data;
  sched_state_t    dbg_state;
  logic [2:0]      dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  logic [RW-1:0] exp_rsp = '0;

  fsm_req_sched #(.NUM_REQ(N), .DATA_W(DW), .RSP_W(RW), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .done          (done),
    .tmo_err       (tmo_err),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .fsm_in_valid  (fsm_in_valid),
    .fsm_in_data   (fsm_in_data),
    .fsm_in_ready  (fsm_in_ready),
    .fsm_out_valid (fsm_out_valid),
    .fsm_out_data  (fsm_out_data),
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference winner: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One full transaction starting from IDLE at a negedge. rsp_dly is the
  // number of edges after accept at which the engine responds (> TMO: never).
  task automatic run_txn(input logic [N-1:0] pat, input int rdy_dly,
                         input int rsp_dly, input logic [RW-1:0] rval);
    int            w;
    logic [DW-1:0] d [N];
    logic [DW-1:0] wd;
    logic [N-1:0]  wg;
    for (int i = 0; i < N; i++) d[i] = DW'($urandom);
    req      = pat;
    req_data = {d[3], d[2], d[1], d[0]};
    fsm_in_ready  = 1'b0;
    fsm_out_valid = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_state", 32'(dbg_state == IDLE), 1);
    chk("idle_rr_ptr", 32'(dbg_rr_ptr), m_ptr);
    w  = model_pick(pat, m_ptr);
    wd = d[w];
    wg = N'(1) << w;
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(wg));
    chk("in_valid_rise", 32'(fsm_in_valid), 1);
    chk("in_data", 32'(fsm_in_data), 32'(wd));
    chk("busy_grant", 32'(busy), 1);
    for (int k = 0; k <= rdy_dly; k++) begin
      req           = N'($urandom);
      req_data      = (N*DW)'($urandom);
      fsm_in_ready  = (k == rdy_dly);
      fsm_out_valid = 1'($urandom_range(0, 1));
      fsm_out_data  = RW'($urandom);
      @(negedge clk);
      if (k < rdy_dly) begin
        chk("in_valid_hold", 32'(fsm_in_valid), 1);
        chk("in_data_hold", 32'(fsm_in_data), 32'(wd));
      end else begin
        chk("in_valid_fall", 32'(fsm_in_valid), 0);
      end
      chk("issue_gnt", 32'(gnt), 32'(wg));
      chk("issue_no_done", 32'(done | tmo_err), 0);
      chk("issue_rsp_hold", 32'(rsp_data), 32'(exp_rsp));
    end
    fsm_in_ready = 1'b0;
    for (int j = 1; j <= TMO; j++) begin
      fsm_out_valid = (j == rsp_dly);
      fsm_out_data  = (j == rsp_dly) ? rval : RW'($urandom);
      req           = N'($urandom);
      @(negedge clk);
      if (j == rsp_dly) begin
        exp_rsp = rval;
        m_ptr   = (w + 1) % N;
        chk("done", 32'(done), 32'(wg));
        chk("done_no_tmo", 32'(tmo_err), 0);
        chk("rsp_data", 32'(rsp_data), 32'(rval));
        chk("done_gnt_clear", 32'(gnt), 0);
        break;
      end else if (j == TMO) begin
        m_ptr = (w + 1) % N;
        chk("tmo_err", 32'(tmo_err), 32'(wg));
        chk("tmo_no_done", 32'(done), 0);
        chk("tmo_gnt_clear", 32'(gnt), 0);
        chk("tmo_rsp_hold", 32'(rsp_data), 32'(exp_rsp));
        break;
      end else begin
        chk("wait_quiet", 32'(done | tmo_err), 0);
        chk("wait_gnt", 32'(gnt), 32'(wg));
        chk("wait_rsp_hold", 32'(rsp_data), 32'(exp_rsp));
      end
    end
    // Idle gap with a stray engine response that must be dropped.
    req           = '0;
    fsm_out_valid = 1'($urandom_range(0, 1));
    fsm_out_data  = RW'($urandom);
    @(negedge clk);
    fsm_out_valid = 1'b0;
    chk("pulse_one_cycle", 32'(done | tmo_err), 0);
    chk("gap_idle", 32'(busy), 0);
    chk("gap_rsp_hold", 32'(rsp_data), 32'(exp_rsp));
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    fsm_in_ready = 1'b0; fsm_out_valid = 1'b0; fsm_out_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_rsp", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_valid", 32'(fsm_in_valid), 0);
    chk("rst_in_data", 32'(fsm_in_data), 0);
    chk("rst_ptr", 32'(dbg_rr_ptr), 0);

    // Single request with a fixed payload/response.
    begin
      logic [DW-1:0] a5 = 8'hA5;
      req      = 4'b0001;
      req_data = {24'h0, a5};
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 1);
      chk("single_data", 32'(fsm_in_data), 32'h A5);
      fsm_in_ready = 1'b1;
      @(negedge clk);
      fsm_in_ready = 1'b0;
      chk("single_accept", 32'(fsm_in_valid), 0);
      repeat (2) @(negedge clk);
      fsm_out_valid = 1'b1; fsm_out_data = 8'h3C;
      @(negedge clk);
      fsm_out_valid = 1'b0; req = '0;
      chk("single_done", 32'(done), 1);
      chk("single_rsp", 32'(rsp_data), 32'h3C);
      exp_rsp = 8'h3C;
      m_ptr   = 1;
      @(negedge clk);
      chk("single_ptr", 32'(dbg_rr_ptr), 1);
    end

    // Fairness: all requesting, engine answers after 2 cycles.
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 0, 2, RW'($urandom));
    // Backpressure for 5 cycles, then a watchdog expiry.
    run_txn(4'b1111, 5, TMO + 4, 8'h00);
    // Timeout on requester 2.
    run_txn(4'b0100, 0, TMO + 4, 8'h00);
    // Response on the last watchdog cycle.
    run_txn(4'b0011, 1, TMO, 8'h5A);

    // Reset in the middle of WAIT_RSP.
    req = 4'b1000;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h8);
    fsm_in_ready = 1'b1;
    @(negedge clk);
    fsm_in_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; exp_rsp = '0;
    chk("abort_outputs", 32'({gnt, done, tmo_err, busy, fsm_in_valid}), 0);
    chk("abort_rsp", 32'(rsp_data), 0);
    chk("abort_ptr", 32'(dbg_rr_ptr), 0);
    fsm_out_valid = 1'b1; fsm_out_data = 8'h77;
    @(negedge clk);
    fsm_out_valid = 1'b0;
    chk("stray_done", 32'(done | tmo_err), 0);
    chk("stray_rsp", 32'(rsp_data), 0);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 4),
              $urandom_range(1, 20), RW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_req_sched.md
Name: fsm_req_sched

Overview:
- Round-robin scheduler that shares one fsm engine between NUM_REQ requesters.
- Sequences each transaction through the engine: issue on the fsm_in side, then await the result on the fsm_out side.
- Routes the result back to the winning requester, with a watchdog timeout on the response.
- Sits between the requester clients and the fsm DUT; the fsm_in and fsm_out agents attach to its engine-side ports.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- DATA_W, 8, request payload width sent to the engine.
- RSP_W, 8, engine response width.
- TIMEOUT, 16, max cycles in WAIT_RSP before error; must be >= 2.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, NUM_REQ, per-requester request level.
- req_data, input, NUM_REQ*DATA_W, payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt, output, NUM_REQ, one-hot grant; held for the whole transaction.
- done, output, NUM_REQ, one-cycle completion pulse to the granted requester.
- tmo_err, output, NUM_REQ, one-cycle timeout pulse to the granted requester.
- rsp_data, output, RSP_W, response; valid when any bit of done is 1, holds its last value otherwise.
- busy, output, 1, high in any state except IDLE.
- fsm_in_valid, output, 1, request valid to the engine.
- fsm_in_data, output, DATA_W, request payload to the engine.
- fsm_in_ready, input, 1, engine accepts the request.
- fsm_out_valid, input, 1, engine response valid (single-cycle).
- fsm_out_data, input, RSP_W, engine response.

Behaviour:
- Reset: all outputs are 0, state=IDLE, rr_ptr=0, timeout counter=0. Reset applied mid-transaction aborts it; no done or tmo_err is issued.
- States: IDLE -> ISSUE -> WAIT_RSP -> IDLE. Every output is registered.
- IDLE:
  - Search order is rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first i with req[i]=1 wins.
  - At that edge: gnt[i]=1, payload captured into an internal register, fsm_in_valid=1, state=ISSUE.
  - Latency: req sampled at edge t gives gnt and fsm_in_valid visible after edge t.
- ISSUE:
  - fsm_in_valid=1 and fsm_in_data holds the captured payload, stable until accepted.
  - On valid&ready at an edge: fsm_in_valid=0, counter=0, state=WAIT_RSP.
  - fsm_out_valid in this state is ignored.
- WAIT_RSP:
  - Counter increments each cycle.
  - fsm_out_valid=1: rsp_data<=fsm_out_data, done[i] pulses next cycle, gnt=0, state=IDLE.
  - Else if counter==TIMEOUT-1: tmo_err[i] pulses next cycle, gnt=0, state=IDLE.
  - Response and timeout on the same cycle: the response wins and no error is raised.
- After done or tmo_err: rr_ptr = (i+1) mod NUM_REQ.
- IDLE lasts at least 1 cycle between transactions; back-to-back throughput is one transaction per 3+ cycles.
- Requester behaviour during a transaction:
  - Dropping req[i] while granted has no effect; the transaction completes.
  - req_data changes after capture are ignored.
- fsm_out_valid received in IDLE or ISSUE is dropped silently.
- Invariants: gnt is one-hot or zero; done and tmo_err are never both asserted; at most one bit of each is set.

Decomposition:
- Shared package fsm_sched_pkg holds:
  - the state enum sched_state_t {IDLE, ISSUE, WAIT_RSP};
  - default parameter constants;
  - a function rr_pick(req, ptr) returning the one-hot winner.
- One sub-module, fsm_rr_arbiter: combinational round-robin pick, with the pointer register kept in the parent.
- The top module holds the state machine, payload capture, timeout counter and response routing.

Test Plan (NUM_REQ=4, DATA_W=8, RSP_W=8, TIMEOUT=16):
- Single request: req=0001, req_data[0]=8'hA5, ready=1, response 8'h3C three cycles after accept -> gnt=0001, fsm_in_data=A5 for one cycle, done=0001 with rsp_data=3C, rr_ptr=1.
- Fairness: req=1111 held, engine responds after 2 cycles -> grant order 0,1,2,3,0; no requester is granted twice before all others.
- Backpressure: fsm_in_ready=0 for 5 cycles -> fsm_in_valid and data stay stable for 6 cycles; the counter does not start until the handshake.
- Timeout: requester 2 granted, no response -> tmo_err=0100 exactly 16 cycles after accept, done stays 0, rr_ptr=3.
- Race: response arrives on the counter==15 cycle -> done pulses and tmo_err stays 0.
- Reset mid-WAIT_RSP, with later stray responses: rst pulsed for 1 cycle -> all outputs are 0 next cycle and rr_ptr=0; a later fsm_out_valid in IDLE is ignored.
